// File: rtl/instruction_fetch.sv
// Instruction fetch stage: 64x32 synchronous-read instruction memory, 8-bit byte PC, branch redirect and stall.
// Optional FETCH_HALT_EN: a fetched 0xFC000000 is presented once, then fetch halts until reset.
module instruction_fetch (
    input  logic        clock,
    input  logic        resetN,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [7:0]  BranchTarget,
    input  logic        LoadEn,
    input  logic [5:0]  LoadAddr,
    input  logic [31:0] LoadData,
    output logic [31:0] InstructionOut,
    output logic [7:0]  PCOut,
    output logic        ValidOut
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } fetchState_e;

    localparam logic [31:0] HaltWord = 32'hFC00_0000;

    fetchState_e stateQ;
    logic [31:0] memQ [64];
    logic [7:0]  issueQ;
    logic [31:0] instrQ;
    logic [7:0]  pcOutQ;
    logic        validQ;

    logic [31:0] readDataD;
    logic [7:0]  nextIssueD;
    logic [7:0]  branchAddrD;
    logic        haltWordD;

    // Memory writes ignore reset and fetch state so software can be loaded while the core is held in reset.
    always_ff @(posedge clock) begin
        if (LoadEn) begin
            memQ[LoadAddr] <= LoadData;
        end
    end

    assign readDataD   = memQ[issueQ[7:2]];
    assign nextIssueD  = issueQ + 8'd4;
    assign branchAddrD = BranchTarget & 8'hFC;

`ifdef FETCH_HALT_EN
    assign haltWordD = (readDataD == HaltWord);
`else
    assign haltWordD = 1'b0;
`endif

    // issueQ holds the address whose read is in flight; the output registers act as the memory's read port.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateQ <= BOOT;
            issueQ <= 8'h00;
            instrQ <= 32'h0000_0000;
            pcOutQ <= 8'h00;
            validQ <= 1'b0;
        end else begin
            case (stateQ)
                BOOT: begin
                    validQ <= 1'b0;
                    if (BranchTaken) begin
                        issueQ <= branchAddrD;
                        stateQ <= REDIRECT;
                    end else if (!Stall) begin
                        issueQ <= 8'h00;
                        stateQ <= RUN;
                    end
                end
                RUN, REDIRECT: begin
                    if (BranchTaken) begin
                        validQ <= 1'b0;
                        issueQ <= branchAddrD;
                        stateQ <= REDIRECT;
                    end else if (!Stall) begin
                        instrQ <= readDataD;
                        pcOutQ <= issueQ;
                        validQ <= 1'b1;
                        issueQ <= nextIssueD;
                        stateQ <= haltWordD ? HALT : RUN;
                    end
                end
                HALT: begin
                    validQ <= 1'b0;
                end
                default: begin
                    stateQ <= BOOT;
                end
            endcase
        end
    end

    assign InstructionOut = instrQ;
    assign PCOut          = pcOutQ;
    assign ValidOut       = validQ;

endmodule
